// File: rtl/dc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_seq_pkg
// Brief    : Shared types and defaults for the DC DAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dc_seq_pkg;

    localparam int DAC_CHANNEL_DEF = 24;
    localparam int FRAME_WORDS_DEF = 62;
    localparam int LAUNCH_WORDS    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FIRE   = 2'd3
    } seq_state_t;

    typedef logic [FRAME_WORDS_DEF-1:0][31:0] frame_t;
    typedef logic [LAUNCH_WORDS-1:0][31:0]    launch_t;

endpackage
`default_nettype wire

// File: rtl/dc_dac_sequencer_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : dc_settle_timer
// Brief    : Loadable down-counter; o_done is high while the count equals 1.
// Revision : 1.0 - initial release
// ============================================================================
module dc_settle_timer #(
    parameter int LOAD_VALUE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int                c_cw   = $clog2(LOAD_VALUE + 1);
    localparam logic [c_cw-1:0]   c_load = c_cw'(LOAD_VALUE);
    localparam logic [c_cw-1:0]   c_one  = c_cw'(1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_load;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_done = (r_count == c_one);

endmodule
`default_nettype wire

// File: rtl/dc_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dc_dac_sequencer
// Brief    : Streams buffered DC frames to the DAC serializer and gates launch
//            commands behind stream completion. DC_SEQ_SETTLE_EN adds a settle
//            delay between the last DC word and the launch strobe.
// Revision : 1.0 - initial release
// ============================================================================
module dc_dac_sequencer
    import dc_seq_pkg::*;
#(
    parameter int DAC_CHANNEL   = DAC_CHANNEL_DEF,
    parameter int FRAME_WORDS   = FRAME_WORDS_DEF,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [FRAME_WORDS-1:0][31:0]  i_dc_regs,
    input  logic [4:0]                    i_channel_sel,
    input  logic                          i_valid_frame,
    input  launch_t                       i_launch_cmd,
    input  logic                          i_launch_valid,
    output logic [31:0]                   o_dac_data,
    output logic [4:0]                    o_dac_ch,
    output logic                          o_dac_valid,
    output logic                          o_dac_last,
    input  logic                          i_dac_ready,
    output launch_t                       o_launch_cmd,
    output logic                          o_launch_fire,
    output logic [DAC_CHANNEL-1:0]        o_ch_done,
    output logic                          o_frame_drop,
    output logic                          o_launch_drop,
    input  logic                          i_clr_status,
    output logic                          o_busy
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_settle_check
            $error("SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    localparam int                     c_iw        = $clog2(FRAME_WORDS);
    localparam logic [c_iw-1:0]        c_first_idx = c_iw'(1);
    localparam logic [c_iw-1:0]        c_last_idx  = c_iw'(FRAME_WORDS - 1);
    localparam logic [31:0]            c_ch_limit  = 32'(DAC_CHANNEL);
    localparam logic [DAC_CHANNEL-1:0] c_ch_one    = DAC_CHANNEL'(1);

    seq_state_t                    r_state;
    logic [FRAME_WORDS-1:0][31:0]  r_buf;
    logic [4:0]                    r_ch;
    logic [c_iw-1:0]               r_idx;
    logic                          r_frm_full;
    logic                          r_launch_pend;
    launch_t                       r_launch_cmd;
    logic [DAC_CHANNEL-1:0]        r_ch_done;
    logic                          r_frame_drop;
    logic                          r_launch_drop;

    logic                          w_accept;
    logic                          w_last;
    logic                          w_stream_end;
    logic                          w_ch_ok;
    logic                          w_frame_take;
    logic                          w_frame_drop;
    logic                          w_launch_take;
    logic                          w_launch_drop;
    logic [DAC_CHANNEL-1:0]        w_done_set;

    assign w_accept      = (r_state == ST_STREAM) && i_dac_ready;
    assign w_last        = (r_idx == c_last_idx);
    assign w_stream_end  = w_accept && w_last;
    assign w_ch_ok       = (32'(i_channel_sel) < c_ch_limit);
    // The buffer frees on the final accept, so a frame landing that cycle is taken.
    assign w_frame_take  = i_valid_frame && w_ch_ok && (!r_frm_full || w_stream_end);
    assign w_frame_drop  = i_valid_frame && !w_frame_take;
    assign w_launch_take = i_launch_valid && !r_launch_pend;
    assign w_launch_drop = i_launch_valid && r_launch_pend;
    assign w_done_set    = w_stream_end ? (c_ch_one << r_ch) : '0;

`ifdef DC_SEQ_SETTLE_EN
    localparam seq_state_t c_launch_state = ST_SETTLE;

    logic w_settle_load;
    logic w_settle_done;

    assign w_settle_load = r_launch_pend && ((r_state == ST_IDLE) || w_stream_end);

    dc_settle_timer #(
        .LOAD_VALUE (SETTLE_CYCLES)
    ) u_settle_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_settle_load),
        .o_done  (w_settle_done)
    );
`else
    localparam seq_state_t c_launch_state = ST_FIRE;
`endif

    // Payload storage carries no reset; every consumer is gated by state.
    always_ff @(posedge i_clk) begin
        if (w_frame_take) begin
            r_buf <= i_dc_regs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_ch          <= '0;
            r_idx         <= '0;
            r_frm_full    <= 1'b0;
            r_launch_pend <= 1'b0;
            r_launch_cmd  <= '0;
            r_ch_done     <= '0;
            r_frame_drop  <= 1'b0;
            r_launch_drop <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_launch_pend) begin
                        r_state <= c_launch_state;
                    end else if (r_frm_full) begin
                        r_state <= ST_STREAM;
                        r_idx   <= c_first_idx;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_idx <= r_idx + c_first_idx;
                        if (w_last) begin
                            r_state <= r_launch_pend ? c_launch_state : ST_IDLE;
                        end
                    end
                end
`ifdef DC_SEQ_SETTLE_EN
                ST_SETTLE: begin
                    if (w_settle_done) begin
                        r_state <= ST_FIRE;
                    end
                end
`endif
                ST_FIRE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_frame_take) begin
                r_frm_full <= 1'b1;
                r_ch       <= i_channel_sel;
            end else if (w_stream_end) begin
                r_frm_full <= 1'b0;
            end

            if (r_state == ST_FIRE) begin
                r_launch_pend <= 1'b0;
            end else if (w_launch_take) begin
                r_launch_pend <= 1'b1;
                r_launch_cmd  <= i_launch_cmd;
            end

            // Status clear loses to a coincident set.
            r_ch_done     <= (i_clr_status ? '0 : r_ch_done) | w_done_set;
            r_frame_drop  <= (r_frame_drop && !i_clr_status) || w_frame_drop;
            r_launch_drop <= (r_launch_drop && !i_clr_status) || w_launch_drop;
        end
    end

    assign o_dac_valid   = (r_state == ST_STREAM);
    assign o_dac_data    = o_dac_valid ? r_buf[r_idx] : '0;
    assign o_dac_ch      = o_dac_valid ? r_ch : '0;
    assign o_dac_last    = o_dac_valid && w_last;
    assign o_launch_cmd  = r_launch_cmd;
    assign o_launch_fire = (r_state == ST_FIRE);
    assign o_ch_done     = r_ch_done;
    assign o_frame_drop  = r_frame_drop;
    assign o_launch_drop = r_launch_drop;
    assign o_busy        = (r_state != ST_IDLE) || r_frm_full || r_launch_pend;

endmodule
`default_nettype wire

// File: tb/tb_dc_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_dac_sequencer
// Brief    : Directed, scoreboard-checked bench for dc_dac_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_dac_sequencer;
    import dc_seq_pkg::*;

    localparam int DAC_CHANNEL   = 24;
    localparam int FRAME_WORDS   = 62;
    localparam int SETTLE_CYCLES = 4;
`ifdef DC_SEQ_SETTLE_EN
    localparam int SETTLE_LAT = SETTLE_CYCLES;
`else
    localparam int SETTLE_LAT = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  ch;
        logic        last;
    } word_t;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [FRAME_WORDS-1:0][31:0]  dc_regs;
    logic [4:0]                    channel_sel;
    logic                          valid_frame;
    launch_t                       launch_cmd;
    logic                          launch_valid;
    logic [31:0]                   dac_data;
    logic [4:0]                    dac_ch;
    logic                          dac_valid;
    logic                          dac_last;
    logic                          dac_ready;
    launch_t                       launch_cmd_o;
    logic                          launch_fire;
    logic [DAC_CHANNEL-1:0]        ch_done;
    logic                          frame_drop;
    logic                          launch_drop;
    logic                          clr_status;
    logic                          busy;

    int    cyc        = 0;
    int    ready_mode = 0;
    int    n_assert   = 0;
    int    n_fail     = 0;
    int    acc_total  = 0;
    word_t exp_q[$];
    int    acc_cyc[$];
    logic  stall_prev = 1'b0;
    word_t held;
    word_t cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign dac_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);

    dc_dac_sequencer #(
        .DAC_CHANNEL   (DAC_CHANNEL),
        .FRAME_WORDS   (FRAME_WORDS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_dc_regs      (dc_regs),
        .i_channel_sel  (channel_sel),
        .i_valid_frame  (valid_frame),
        .i_launch_cmd   (launch_cmd),
        .i_launch_valid (launch_valid),
        .o_dac_data     (dac_data),
        .o_dac_ch       (dac_ch),
        .o_dac_valid    (dac_valid),
        .o_dac_last     (dac_last),
        .i_dac_ready    (dac_ready),
        .o_launch_cmd   (launch_cmd_o),
        .o_launch_fire  (launch_fire),
        .o_ch_done      (ch_done),
        .o_frame_drop   (frame_drop),
        .o_launch_drop  (launch_drop),
        .i_clr_status   (clr_status),
        .o_busy         (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int acc_at(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
    endfunction

    // Scoreboard consumer plus stall-stability watch.
    always @(negedge clk) begin
        if (stall_prev)
            check("stall_hold", {dac_valid, dac_data, dac_ch, dac_last}, {1'b1, held});
        if (rst_n && dac_valid && dac_ready) begin
            acc_total++;
            acc_cyc.push_back(cyc);
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_word: observed %0h expected none", dac_data);
            end
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("dac_word", {dac_data, dac_ch, dac_last}, cur);
            end
        end
        stall_prev = rst_n && dac_valid && !dac_ready;
        held       = {dac_data, dac_ch, dac_last};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        step();
        valid_frame  = 1'b0;
        launch_valid = 1'b0;
        clr_status   = 1'b0;
    endtask

    task automatic arm_frame(input logic [31:0] base, input logic [4:0] ch, input bit expect_stream);
        word_t w;
        for (int k = 0; k < FRAME_WORDS; k++) dc_regs[k] = base + 32'(k);
        channel_sel = ch;
        valid_frame = 1'b1;
        if (expect_stream) begin
            for (int k = 1; k < FRAME_WORDS; k++) begin
                w.data = base + 32'(k);
                w.ch   = ch;
                w.last = (k == FRAME_WORDS - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        step();
        check({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    task automatic wait_fire(output int fc, input int budget);
        int n = 0;
        fc = -1;
        @(negedge clk);
        while (!launch_fire && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (launch_fire) fc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int      t0;
        int      fc;
        int      n;
        int      total;
        launch_t cmd_a;
        launch_t cmd_b;
        launch_t cmd_c;

        cmd_a = 128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000;
        cmd_b = 128'hB1B1_0003_B1B1_0002_B1B1_0001_B1B1_0000;
        cmd_c = 128'hC2C2_0003_C2C2_0002_C2C2_0001_C2C2_0000;

        rst_n        = 1'b0;
        dc_regs      = '0;
        channel_sel  = '0;
        valid_frame  = 1'b0;
        launch_cmd   = '0;
        launch_valid = 1'b0;
        clr_status   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", dac_valid, 1'b0);
        check("rst_data", dac_data, 32'h0);
        check("rst_fire", launch_fire, 1'b0);
        check("rst_status", {ch_done, frame_drop, launch_drop}, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd", launch_cmd_o, 128'h0);
        rst_n = 1'b1;
        step();
        step();

        // Full-rate frame on channel 5.
        ready_mode = 0;
        acc_cyc.delete();
        arm_frame(32'h1000_0000, 5'd5, 1'b1);
        t0 = cyc;
        pulse();
        wait_drain("t1", 200);
        check("t1_count", acc_cyc.size(), 61);
        check("t1_first_cyc", acc_at(0), t0 + 2);
        check("t1_last_cyc", acc_at(60), t0 + 62);
        check("t1_ch_done", ch_done, 24'h00_0020);
        check("t1_idle", busy, 1'b0);

        // Same frame under 1-in-3 ready.
        clr_status = 1'b1;
        pulse();
        check("t2_clr_done", ch_done, 24'h0);
        ready_mode = 1;
        acc_cyc.delete();
        arm_frame(32'h1000_0000, 5'd5, 1'b1);
        pulse();
        wait_drain("t2", 400);
        check("t2_count", acc_cyc.size(), 61);
        check("t2_ch_done", ch_done, 24'h00_0020);
        ready_mode = 0;
        step();

        // Launch ten cycles into a stream waits for the stream and settle.
        acc_cyc.delete();
        arm_frame(32'h3000_0000, 5'd11, 1'b1);
        t0 = cyc;
        pulse();
        repeat (11) step();
        launch_cmd   = cmd_a;
        launch_valid = 1'b1;
        pulse();
        wait_fire(fc, 300);
        check("t3_fire_cyc", fc, t0 + 62 + 1 + SETTLE_LAT);
        check("t3_fire_cmd", launch_cmd_o, cmd_a);
        @(negedge clk);
        check("t3_fire_pulse", launch_fire, 1'b0);
        step();
        check("t3_last_cyc", acc_at(60), t0 + 62);
        wait_drain("t3", 10);

        // Frame on the last-accept cycle is taken; a frame during its stream drops.
        clr_status = 1'b1;
        pulse();
        acc_cyc.delete();
        arm_frame(32'h4000_0000, 5'd3, 1'b1);
        t0 = cyc;
        pulse();
        repeat (61) step();
        arm_frame(32'h5000_0000, 5'd7, 1'b1);
        pulse();
        check("t4_no_drop_on_last", frame_drop, 1'b0);
        repeat (5) step();
        arm_frame(32'h6000_0000, 5'd8, 1'b0);
        pulse();
        check("t4_drop_full", frame_drop, 1'b1);
        wait_drain("t4", 200);
        check("t4_second_first_cyc", acc_at(61), t0 + 64);
        check("t4_second_last_cyc", acc_at(121), t0 + 124);
        check("t4_count", acc_cyc.size(), 122);
        check("t4_ch_done", ch_done, 24'h00_0088);
        clr_status = 1'b1;
        pulse();
        check("t4_clr_status", {ch_done, frame_drop}, 0);
        arm_frame(32'h7000_0000, 5'd24, 1'b0);
        clr_status = 1'b1;
        pulse();
        check("t4_bad_ch_set_wins", frame_drop, 1'b1);
        check("t4_bad_ch_idle", busy, 1'b0);
        clr_status = 1'b1;
        pulse();
        check("t4_clr_again", frame_drop, 1'b0);

        // Frame and launch together: launch first; second launch drops.
        acc_cyc.delete();
        launch_cmd   = cmd_b;
        launch_valid = 1'b1;
        arm_frame(32'h8000_0000, 5'd20, 1'b1);
        t0 = cyc;
        pulse();
        launch_cmd   = cmd_c;
        launch_valid = 1'b1;
        pulse();
        check("t5_launch_drop", launch_drop, 1'b1);
        wait_fire(fc, 100);
        check("t5_fire_cyc", fc, t0 + 2 + SETTLE_LAT);
        check("t5_fire_cmd", launch_cmd_o, cmd_b);
        step();
        wait_drain("t5", 200);
        check("t5_frame_first", acc_at(0), t0 + 2 + SETTLE_LAT + 2);
        check("t5_count", acc_cyc.size(), 61);
        check("t5_busy", busy, 1'b0);

        // Asynchronous reset at word 30; nothing resumes.
        clr_status = 1'b1;
        pulse();
        acc_cyc.delete();
        arm_frame(32'h9000_0000, 5'd9, 1'b1);
        pulse();
        n = 0;
        while (acc_cyc.size() < 30 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("t6_word30", acc_cyc.size(), 30);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", dac_valid, 1'b0);
        check("t6_rst_data", {dac_data, dac_ch, dac_last}, 0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_status", {ch_done, frame_drop, launch_drop, launch_fire}, 0);
        exp_q.delete();
        total = acc_total;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) step();
        check("t6_no_words", acc_total - total, 0);
        check("t6_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
